// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: op codes and FSM state type shared by the ALU sequencer files.
package alu_seq_pkg;
    localparam logic [3:0] OP_OR   = 4'd0;
    localparam logic [3:0] OP_AND  = 4'd1;
    localparam logic [3:0] OP_NOT  = 4'd2;
    localparam logic [3:0] OP_ADD  = 4'd3;
    localparam logic [3:0] OP_SUB  = 4'd4;
    localparam logic [3:0] OP_SHR  = 4'd5;
    localparam logic [3:0] OP_SHRA = 4'd6;
    localparam logic [3:0] OP_SHL  = 4'd7;
    localparam logic [3:0] OP_ROR  = 4'd8;
    localparam logic [3:0] OP_ROL  = 4'd9;
    localparam logic [3:0] OP_NEG  = 4'd10;
    localparam logic [3:0] OP_MUL  = 4'd11;
    localparam logic [3:0] OP_DIV  = 4'd12;
    localparam logic [3:0] OP_LAST = 4'd12;
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
endpackage

// File: rtl/alu_sequencer_if.sv
// alu_sequencer_if: request, ALU-operand and response bundle; master = sequencer side.
interface alu_sequencer_if;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_op;
    logic [63:0] alu_result;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_hi;
    logic [31:0] rsp_lo;
    logic        rsp_err;
    logic        busy;
    modport master (
        input  req_valid, req_op, req_a, req_b, alu_result, rsp_ready,
        output req_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_hi, rsp_lo, rsp_err, busy
    );
    modport slave (
        output req_valid, req_op, req_a, req_b, alu_result, rsp_ready,
        input  req_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_hi, rsp_lo, rsp_err, busy
    );
endinterface

// File: rtl/alu_seq_lat_decode.sv
// alu_seq_lat_decode: maps an op code to its hold latency and validity.
module alu_seq_lat_decode
    import alu_seq_pkg::*;
#(
    parameter int ALU_CYCLES = 1,
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 8
) (
    input  logic [3:0] op,
    output logic [7:0] latency,
    output logic       op_valid
);
    if (ALU_CYCLES < 1 || ALU_CYCLES > 255 || MUL_CYCLES < 1 || MUL_CYCLES > 255 ||
        DIV_CYCLES < 1 || DIV_CYCLES > 255) begin : g_bad_cycles
        $error("alu_seq_lat_decode: cycle counts must be in 1..255");
    end
    // Invalid ops respond after a single cycle, like a latency-1 op.
    always_comb begin
        op_valid = op <= OP_LAST;
        latency  = op == OP_MUL ? 8'(MUL_CYCLES) :
                   op == OP_DIV ? 8'(DIV_CYCLES) :
                   op_valid     ? 8'(ALU_CYCLES) : 8'd1;
    end
endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: holds ALU operands for an op-dependent number of cycles, then returns HI/LO.
// Define ALU_SEQ_DIVZERO_CHECK_EN to reject DIV with a zero divisor instead of executing it.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int ALU_CYCLES = 1,
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 8
) (
    input logic             clock,
    input logic             clear,
    alu_sequencer_if.master bus
);
    state_t     state, state_n;
    logic [7:0] cnt, latency;
    logic       op_valid, div_zero, bad, fail;
    alu_seq_lat_decode #(
        .ALU_CYCLES(ALU_CYCLES),
        .MUL_CYCLES(MUL_CYCLES),
        .DIV_CYCLES(DIV_CYCLES)
    ) u_lat (
        .op      (bus.req_op),
        .latency (latency),
        .op_valid(op_valid)
    );
`ifdef ALU_SEQ_DIVZERO_CHECK_EN
    assign div_zero = bus.req_op == OP_DIV && bus.req_b == '0;
`else
    assign div_zero = 1'b0;
`endif
    assign bad           = !op_valid || div_zero;
    assign bus.req_ready = state == IDLE;
    assign bus.rsp_valid = state == DONE;
    assign bus.busy      = state != IDLE;
    always_comb begin
        state_n = state;
        state_n = state == IDLE ? (bus.req_valid ? EXEC : IDLE) :
                  state == EXEC ? (cnt == '0 ? DONE : EXEC) :
                  (bus.rsp_ready ? IDLE : DONE);
    end
    // Rejected ops still pass through one EXEC cycle so every response appears after E1 or later.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state       <= IDLE;
            cnt         <= '0;
            fail        <= 1'b0;
            bus.alu_a   <= '0;
            bus.alu_b   <= '0;
            bus.alu_op  <= '0;
            bus.rsp_hi  <= '0;
            bus.rsp_lo  <= '0;
            bus.rsp_err <= 1'b0;
        end else begin
            state <= state_n;
            if (state == IDLE && bus.req_valid) begin
                bus.alu_a  <= bus.req_a;
                bus.alu_b  <= bus.req_b;
                bus.alu_op <= bus.req_op;
                cnt        <= bad ? 8'd0 : latency - 8'd1;
                fail       <= bad;
            end else if (state == EXEC) begin
                if (cnt != '0) begin
                    cnt <= cnt - 8'd1;
                end else begin
                    bus.rsp_hi  <= fail ? 32'd0 : bus.alu_result[63:32];
                    bus.rsp_lo  <= fail ? 32'd0 : bus.alu_result[31:0];
                    bus.rsp_err <= fail;
                end
            end
        end
    end
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed self-checking bench for alu_sequencer with a small ALU model.
module tb_alu_sequencer;
    import alu_seq_pkg::*;
    logic        clock = 1'b0;
    logic        clear = 1'b1;
    int          checks = 0;
    int          errors = 0;
    logic [63:0] sx_prod;
    alu_sequencer_if bus();
    alu_sequencer dut (
        .clock(clock),
        .clear(clear),
        .bus  (bus.master)
    );
    always #5 clock = ~clock;
    // Stand-in datapath ALU: signed MUL, {remainder,quotient} DIV, recognisable junk otherwise.
    always_comb begin
        sx_prod = {{32{bus.alu_a[31]}}, bus.alu_a} * {{32{bus.alu_b[31]}}, bus.alu_b};
        bus.alu_result = bus.alu_op == OP_ADD ? {32'd0, bus.alu_a + bus.alu_b} :
                         bus.alu_op == OP_MUL ? sx_prod :
                         bus.alu_op == OP_DIV ? (bus.alu_b == '0 ? {bus.alu_a, 32'hFFFF_FFFF} :
                                                 {bus.alu_a % bus.alu_b, bus.alu_a / bus.alu_b}) :
                         64'h0BAD_0BAD_0BAD_0BAD;
    end

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.req_op = op;
        bus.req_a = a;
        bus.req_b = b;
        bus.req_valid = 1'b1;
        @(posedge clock);
        #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        while (!bus.rsp_valid && n < 20) begin
            @(posedge clock);
            #1;
            n++;
        end
    endtask

    task automatic handshake;
        bus.rsp_ready = 1'b1;
        @(posedge clock);
        #1;
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_reset;
        #12;
        checks++;
        if ({bus.req_ready, bus.rsp_valid, bus.busy, bus.rsp_err} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_flags got %b exp 1000", {bus.req_ready, bus.rsp_valid, bus.busy, bus.rsp_err});
        end
        checks++;
        if ({bus.alu_a, bus.alu_b, bus.alu_op, bus.rsp_hi, bus.rsp_lo} !== 132'd0) begin
            errors++;
            $display("FAIL reset_regs got %h exp 0", {bus.alu_a, bus.alu_b, bus.alu_op, bus.rsp_hi, bus.rsp_lo});
        end
        @(posedge clock);
        #1;
        clear = 1'b0;
    endtask

    task automatic test_add;
        bus.rsp_ready = 1'b1;
        issue(OP_ADD, 32'd5, 32'd7);
        checks++;
        if ({bus.busy, bus.rsp_valid, bus.req_ready} !== 3'b100) begin
            errors++;
            $display("FAIL add_exec_flags got %b exp 100", {bus.busy, bus.rsp_valid, bus.req_ready});
        end
        checks++;
        if ({bus.alu_op, bus.alu_a, bus.alu_b} !== {OP_ADD, 32'd5, 32'd7}) begin
            errors++;
            $display("FAIL add_operands got %h exp %h", {bus.alu_op, bus.alu_a, bus.alu_b}, {OP_ADD, 32'd5, 32'd7});
        end
        @(posedge clock);
        #1;
        checks++;
        if ({bus.busy, bus.rsp_valid, bus.rsp_hi, bus.rsp_lo, bus.rsp_err} !== {2'b11, 32'd0, 32'd12, 1'b0}) begin
            errors++;
            $display("FAIL add_result got %h exp %h", {bus.busy, bus.rsp_valid, bus.rsp_hi, bus.rsp_lo, bus.rsp_err},
                     {2'b11, 32'd0, 32'd12, 1'b0});
        end
        @(posedge clock);
        #1;
        bus.rsp_ready = 1'b0;
        checks++;
        if ({bus.busy, bus.rsp_valid, bus.req_ready, bus.rsp_lo} !== {3'b001, 32'd12}) begin
            errors++;
            $display("FAIL add_idle got %h exp %h", {bus.busy, bus.rsp_valid, bus.req_ready, bus.rsp_lo}, {3'b001, 32'd12});
        end
    endtask

    task automatic test_mul;
        issue(OP_MUL, 32'hFFFF_FFFF, 32'd2);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if ({bus.alu_op, bus.alu_a, bus.alu_b, bus.rsp_valid, bus.req_ready} !== {OP_MUL, 32'hFFFF_FFFF, 32'd2, 2'b00}) begin
                errors++;
                $display("FAIL mul_hold cycle %0d got %h exp %h", k, {bus.alu_op, bus.alu_a, bus.alu_b, bus.rsp_valid, bus.req_ready},
                         {OP_MUL, 32'hFFFF_FFFF, 32'd2, 2'b00});
            end
            @(posedge clock);
            #1;
        end
        checks++;
        if ({bus.rsp_valid, bus.rsp_hi, bus.rsp_lo, bus.rsp_err} !== {1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0}) begin
            errors++;
            $display("FAIL mul_result got %h exp %h", {bus.rsp_valid, bus.rsp_hi, bus.rsp_lo, bus.rsp_err},
                     {1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0});
        end
        handshake();
    endtask

    task automatic test_div_backpressure;
        int n;
        issue(OP_DIV, 32'd17, 32'd5);
        wait_rsp(n);
        checks++;
        if (n !== 8) begin
            errors++;
            $display("FAIL div_latency got %0d exp 8", n);
        end
        bus.req_op = OP_ADD;
        bus.req_a = 32'd2;
        bus.req_b = 32'd3;
        bus.req_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clock);
            #1;
            checks++;
            if ({bus.rsp_valid, bus.req_ready, bus.alu_op, bus.rsp_hi, bus.rsp_lo} !== {2'b10, OP_DIV, 32'd2, 32'd3}) begin
                errors++;
                $display("FAIL div_stall cycle %0d got %h exp %h", k, {bus.rsp_valid, bus.req_ready, bus.alu_op, bus.rsp_hi, bus.rsp_lo},
                         {2'b10, OP_DIV, 32'd2, 32'd3});
            end
        end
        handshake();
        checks++;
        if ({bus.rsp_valid, bus.req_ready, bus.alu_op} !== {2'b01, OP_DIV}) begin
            errors++;
            $display("FAIL div_handshake got %h exp %h", {bus.rsp_valid, bus.req_ready, bus.alu_op}, {2'b01, OP_DIV});
        end
        @(posedge clock);
        #1;
        bus.req_valid = 1'b0;
        checks++;
        if ({bus.busy, bus.alu_op, bus.alu_a, bus.alu_b} !== {1'b1, OP_ADD, 32'd2, 32'd3}) begin
            errors++;
            $display("FAIL next_accept got %h exp %h", {bus.busy, bus.alu_op, bus.alu_a, bus.alu_b}, {1'b1, OP_ADD, 32'd2, 32'd3});
        end
        wait_rsp(n);
        checks++;
        if ({n[7:0], bus.rsp_hi, bus.rsp_lo} !== {8'd1, 32'd0, 32'd5}) begin
            errors++;
            $display("FAIL next_result got %h exp %h", {n[7:0], bus.rsp_hi, bus.rsp_lo}, {8'd1, 32'd0, 32'd5});
        end
        handshake();
    endtask

    task automatic test_invalid;
        int n;
        issue(4'd14, 32'd1, 32'd1);
        wait_rsp(n);
        checks++;
        if ({n[7:0], bus.rsp_hi, bus.rsp_lo, bus.rsp_err, bus.alu_op} !== {8'd1, 64'd0, 1'b1, 4'd14}) begin
            errors++;
            $display("FAIL invalid_op got %h exp %h", {n[7:0], bus.rsp_hi, bus.rsp_lo, bus.rsp_err, bus.alu_op},
                     {8'd1, 64'd0, 1'b1, 4'd14});
        end
        handshake();
    endtask

    task automatic test_divzero;
        int n;
        issue(OP_DIV, 32'd9, 32'd0);
        wait_rsp(n);
        checks++;
`ifdef ALU_SEQ_DIVZERO_CHECK_EN
        if ({n[7:0], bus.rsp_hi, bus.rsp_lo, bus.rsp_err, bus.alu_b} !== {8'd1, 64'd0, 1'b1, 32'd0}) begin
            errors++;
            $display("FAIL divzero got %h exp %h", {n[7:0], bus.rsp_hi, bus.rsp_lo, bus.rsp_err, bus.alu_b},
                     {8'd1, 64'd0, 1'b1, 32'd0});
        end
`else
        if ({n[7:0], bus.rsp_hi, bus.rsp_lo, bus.rsp_err, bus.alu_b} !== {8'd8, 32'd9, 32'hFFFF_FFFF, 1'b0, 32'd0}) begin
            errors++;
            $display("FAIL divzero got %h exp %h", {n[7:0], bus.rsp_hi, bus.rsp_lo, bus.rsp_err, bus.alu_b},
                     {8'd8, 32'd9, 32'hFFFF_FFFF, 1'b0, 32'd0});
        end
`endif
        handshake();
    endtask

    task automatic test_clear_mid_mul;
        int n;
        issue(OP_MUL, 32'd3, 32'd4);
        @(posedge clock);
        #1;
        @(posedge clock);
        #1;
        clear = 1'b1;
        #2;
        checks++;
        if ({bus.req_ready, bus.rsp_valid, bus.busy, bus.rsp_err} !== 4'b1000) begin
            errors++;
            $display("FAIL clear_flags got %b exp 1000", {bus.req_ready, bus.rsp_valid, bus.busy, bus.rsp_err});
        end
        checks++;
        if ({bus.alu_a, bus.alu_b, bus.alu_op, bus.rsp_hi, bus.rsp_lo} !== 132'd0) begin
            errors++;
            $display("FAIL clear_regs got %h exp 0", {bus.alu_a, bus.alu_b, bus.alu_op, bus.rsp_hi, bus.rsp_lo});
        end
        @(posedge clock);
        #1;
        clear = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clock);
            #1;
            checks++;
            if ({bus.rsp_valid, bus.busy} !== 2'b00) begin
                errors++;
                $display("FAIL clear_no_rsp cycle %0d got %b exp 00", k, {bus.rsp_valid, bus.busy});
            end
        end
        issue(OP_ADD, 32'd1, 32'd1);
        wait_rsp(n);
        checks++;
        if ({n[7:0], bus.rsp_hi, bus.rsp_lo, bus.rsp_err} !== {8'd1, 32'd0, 32'd2, 1'b0}) begin
            errors++;
            $display("FAIL after_clear got %h exp %h", {n[7:0], bus.rsp_hi, bus.rsp_lo, bus.rsp_err}, {8'd1, 32'd0, 32'd2, 1'b0});
        end
        handshake();
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_op = '0;
        bus.req_a = '0;
        bus.req_b = '0;
        bus.rsp_ready = 1'b0;
        test_reset();
        test_add();
        test_mul();
        test_div_backpressure();
        test_invalid();
        test_divzero();
        test_clear_mid_mul();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
